// File: rtl/hazard_defs.sv
// ---------------------------------------------------------------------------
// hazard_defs: shared definitions for the hazard / stall control slice.
//   - state_t       : controller states (ST_RUN = 0, ST_MD_WAIT = 1)
//   - DEF_MULDIV_LAT: default EX-stage latency of a mul/div operation
//   - ZERO_REG      : index of the hard-wired zero register
//   - load_use_hit  : load-use hazard detect between the ID and EX stages
// ---------------------------------------------------------------------------
package hazard_defs;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  localparam int         DEF_MULDIV_LAT = 4;
  localparam logic [4:0] ZERO_REG       = 5'd0;

  // A load writing r0 never creates a real dependency, so it is excluded.
  function automatic logic load_use_hit(
    input logic       ex_mem_read,
    input logic [4:0] ex_write_reg,
    input logic       id_uses_rs,
    input logic [4:0] id_rs,
    input logic       id_uses_rt,
    input logic [4:0] id_rt
  );
    load_use_hit = ex_mem_read & (ex_write_reg != ZERO_REG) &
                   ((id_uses_rs & (ex_write_reg == id_rs)) |
                    (id_uses_rt & (ex_write_reg == id_rt)));
  endfunction

endpackage

// File: rtl/stall_down_counter.sv
// ---------------------------------------------------------------------------
// stall_down_counter: loadable down counter that times the mul/div wait.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  synchronous active-high reset, clears cnt
//   load     in  load load_val (takes priority over dec)
//   load_val in  CNT_W value to load
//   dec      in  decrement by one (never wraps below zero)
//   cnt      out current count
//   one_flag out cnt == 1, the controller's exit condition
// ---------------------------------------------------------------------------
module stall_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             one_flag
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: reset, load, or saturating decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt      = cnt_r;
  assign one_flag = (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl: drives stall / bubble / flush controls of the IF/ID,
// ID/EX and EX/MEM pipeline registers. Handles load-use stalls, multi-cycle
// mul/div occupancy of EX and taken-branch squash resolved in MEM.
// Outputs are combinational so their effect lands on the next rising edge.
// Ports:
//   Clk, Reset          clock / synchronous active-high reset
//   ID_Rs, ID_Rt        source fields of the ID instruction
//   ID_UsesRs/Rt        the ID instruction reads rs / rt
//   EX_MemRead          EX instruction is a load
//   EX_WriteReg         EX destination register
//   EX_MulDivStart      a mul/div entered EX this cycle
//   MEM_BranchTaken     branch resolved taken in MEM
//   PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, IDEX_Hold, EXMEM_Bubble
//                       pipeline register controls
//   Busy                controller is in the mul/div wait state
// Optional build macro HAZ_STALL_COUNT_EN adds StallCycles (32b) and
// FlushCount (16b) saturating performance counters.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_defs::*;
#(
  parameter int MULDIV_LAT = DEF_MULDIV_LAT,
  parameter int CNT_W      = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_WriteReg,
  input  logic        EX_MulDivStart,
  input  logic        MEM_BranchTaken,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        IDEX_Hold,
  output logic        EXMEM_Bubble,
`ifdef HAZ_STALL_COUNT_EN
  output logic [31:0] StallCycles,
  output logic [15:0] FlushCount,
`endif
  output logic        Busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MULDIV_LAT - 1);
  localparam logic             MULTI  = (MULDIV_LAT > 1);

  state_t           state_r;
  logic             lu_s;
  logic             md_load_s;
  logic             cnt_dec_s;
  logic             cnt_one_s;
  logic             flush_acc_s;
  logic [CNT_W-1:0] cnt_s;

  assign lu_s = load_use_hit(EX_MemRead, EX_WriteReg, ID_UsesRs, ID_Rs,
                             ID_UsesRt, ID_Rt);

  // A branch in MEM squashes the EX mul/div, so it blocks the wait entry.
  assign md_load_s   = ~Reset & (state_r == ST_RUN) & ~MEM_BranchTaken &
                       EX_MulDivStart & MULTI;
  assign cnt_dec_s   = (state_r == ST_MD_WAIT) & (cnt_s != {CNT_W{1'b0}});
  assign flush_acc_s = ~Reset & (state_r == ST_RUN) & MEM_BranchTaken;

  stall_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (Clk),
    .reset    (Reset),
    .load     (md_load_s),
    .load_val (LAT_M1),
    .dec      (cnt_dec_s),
    .cnt      (cnt_s),
    .one_flag (cnt_one_s)
  );

  // Controller state: enter the wait on a multi-cycle start, leave at cnt==1.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:     state_r <= md_load_s ? ST_MD_WAIT : ST_RUN;
        ST_MD_WAIT: state_r <= cnt_one_s ? ST_RUN : ST_MD_WAIT;
        default:    state_r <= ST_RUN;
      endcase
    end
  end

  // Pipeline control decode in priority order: branch, mul/div, load-use.
  always_comb begin
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    IDEX_Hold    = 1'b0;
    EXMEM_Bubble = 1'b0;
    Busy         = 1'b0;
    if (Reset) begin
      PCWrite = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (MEM_BranchTaken) begin
            IFID_Flush   = 1'b1;
            IDEX_Bubble  = 1'b1;
            EXMEM_Bubble = 1'b1;
          end else if (EX_MulDivStart && MULTI) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Hold    = 1'b1;
            EXMEM_Bubble = 1'b1;
          end else if (EX_MulDivStart) begin
            // Single-cycle mul/div needs no stall.
            PCWrite = 1'b1;
          end else if (lu_s) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
          end else begin
            PCWrite = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          PCWrite      = 1'b0;
          IFID_Write   = 1'b0;
          IDEX_Hold    = 1'b1;
          EXMEM_Bubble = 1'b1;
          Busy         = 1'b1;
        end
        default: begin
          PCWrite = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZ_STALL_COUNT_EN
  logic [31:0] stall_cycles_r;
  logic [15:0] flush_count_r;

  // Saturating stall-cycle and accepted-flush counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cycles_r <= 32'd0;
      flush_count_r  <= 16'd0;
    end else begin
      if (!PCWrite && (stall_cycles_r != 32'hFFFF_FFFF)) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (flush_acc_s && (flush_count_r != 16'hFFFF)) begin
        flush_count_r <= flush_count_r + 16'd1;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign StallCycles = stall_cycles_r;
  assign FlushCount  = flush_count_r;
`else
  logic unused_s;
  assign unused_s = flush_acc_s;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control block that drives the stall, bubble and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards between the ID and EX stages and multi-cycle mul/div occupancy of EX.
- Handles taken-branch squash resolved in MEM.
- Sits beside the ID/EX register: it decides what that register captures each cycle (new instruction, bubble, or hold).

Parameters:
- MULDIV_LAT, 4, total EX-stage cycles of a mul/div op (legal range 1..16).
- CNT_W, 4, width of the internal wait counter; must satisfy 2^CNT_W > MULDIV_LAT.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRs  in  1  the ID instruction reads rs.
- ID_UsesRt  in  1  the ID instruction reads rt.
- EX_MemRead  in  1  the EX instruction is a load.
- EX_WriteReg  in  5  destination register of the EX instruction (after the RegDst mux).
- EX_MulDivStart  in  1  a mul/div entered EX this cycle.
- MEM_BranchTaken  in  1  a branch resolved taken in MEM.
- PCWrite  out  1  PC update enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  zero the IF/ID register.
- IDEX_Bubble  out  1  load zero controls into ID/EX.
- IDEX_Hold  out  1  ID/EX keeps its current contents.
- EXMEM_Bubble  out  1  load zero controls into EX/MEM.
- Busy  out  1  state is MD_WAIT.

Behaviour:
- State register, 2 states: RUN, MD_WAIT. Wait counter cnt is CNT_W bits wide.
- All outputs are combinational from state, cnt and current inputs. Zero-latency: effects apply at the next rising edge.
- Default outputs (RUN, no event): PCWrite=1, IFID_Write=1, all others 0.
- Reset: state=RUN, cnt=0 on the edge. While Reset=1, outputs are forced to the defaults regardless of inputs.
- Load-use condition LU: EX_MemRead & (EX_WriteReg!=0) & ((ID_UsesRs & EX_WriteReg==ID_Rs) | (ID_UsesRt & EX_WriteReg==ID_Rt)).
- RUN priority, highest first:
  1. MEM_BranchTaken: IFID_Flush=1, IDEX_Bubble=1, EXMEM_Bubble=1, PCWrite=1. EX_MulDivStart and LU are ignored because the EX instruction is squashed. Stay in RUN.
  2. EX_MulDivStart: PCWrite=0, IFID_Write=0, IDEX_Hold=1, EXMEM_Bubble=1.
     - If MULDIV_LAT>1: go to MD_WAIT with cnt=MULDIV_LAT-1.
     - If MULDIV_LAT=1: no stall; default outputs and stay in RUN.
  3. LU: PCWrite=0, IFID_Write=0, IDEX_Bubble=1 for exactly one cycle; stay in RUN. On the next cycle the load is in MEM, so LU clears naturally.
- MD_WAIT, every cycle:
  - PCWrite=0, IFID_Write=0, IDEX_Hold=1, EXMEM_Bubble=1, Busy=1; cnt decrements.
  - When cnt==1 on the edge, cnt becomes 0 and state goes to RUN.
  - Total stalled cycles including the start cycle = MULDIV_LAT.
  - MEM_BranchTaken, EX_MulDivStart and LU are ignored. MEM only holds bubbles after the start cycle, so a branch cannot resolve here.
- Mid-operation reset: returns to RUN with cnt=0 on the same edge. The pending mul/div is abandoned.
- IDEX_Hold and IDEX_Bubble are never both 1. IFID_Flush and IFID_Write=0 are never both asserted.

Optional Feature:
- Macro: HAZ_STALL_COUNT_EN.
- Defined:
  - Adds output StallCycles (32 bits), cleared by Reset.
  - Increments on every cycle with PCWrite=0, saturating at 0xFFFFFFFF.
  - Adds output FlushCount (16 bits), which increments on each MEM_BranchTaken accepted in RUN and also saturates.
- Undefined: neither port nor its counter logic exists.

Decomposition:
- Shared package/header hazard_defs:
  - State encodings (RUN=0, MD_WAIT=1).
  - Default MULDIV_LAT.
  - A localparam for the zero-register index.
- One natural sub-module, stall_down_counter:
  - Loadable, decrementing CNT_W counter.
  - Inputs: load, load_val, dec.
  - Outputs: cnt and a one_flag (cnt==1) used as the FSM exit condition.

Test Plan:
- Load-use: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8, ID_UsesRs=1 → one cycle with PCWrite=0, IFID_Write=0, IDEX_Bubble=1. The next cycle (EX_MemRead=0) returns to defaults.
- Zero-register guard: EX_MemRead=1, EX_WriteReg=0, ID_Rt=0, ID_UsesRt=1 → no stall; outputs stay at defaults.
- Mul/div with MULDIV_LAT=4: EX_MulDivStart pulse → exactly 4 consecutive cycles with IDEX_Hold=1 and EXMEM_Bubble=1; Busy=1 for cycles 2-4; defaults on cycle 5.
- Branch priority: MEM_BranchTaken=1 with EX_MulDivStart=1 and LU true in the same cycle → IFID_Flush=1, IDEX_Bubble=1, EXMEM_Bubble=1, PCWrite=1; the next cycle is in RUN with Busy=0.
- Reset mid-wait: Reset asserted in the 2nd MD_WAIT cycle → the next cycle is RUN with defaults. A new EX_MulDivStart then gives a full MULDIV_LAT stall.
- HAZ_STALL_COUNT_EN: 1 load-use stall plus one 4-cycle mul/div → StallCycles=5. Counter preloaded via force to 0xFFFFFFFF stays at 0xFFFFFFFF after further stalls.
